conv_stream_scheduler: RTL and testbench

CONV_STREAM_SCHEDULER -- requirements
Module: conv_stream_scheduler

---
 rtl/conv_sched_pkg.sv | 36 +++
 rtl/conv_stream_scheduler_if.sv | 38 +++
 rtl/frame_scan_counter.sv | 68 ++++++
 rtl/conv_stream_scheduler.sv | 111 +++++++++++
 tb/tb_conv_stream_scheduler.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_sched_pkg.sv
// Shared state encoding and derived-constant helpers for the convolution stream scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    FINISH
  } sched_state_t;

  localparam int unsigned DEF_CH_IN = 128;
  localparam int unsigned DEF_K_S   = 3;
  localparam int unsigned DEF_W_IN  = 32;
  localparam int unsigned DEF_PAD   = 1;
  localparam int unsigned DEF_DRAIN = 4;

  // Counter/address width for a range of n values; never below one bit.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned w_beats(input int unsigned ch_in, input int unsigned k_s);
    return ch_in * k_s * k_s;
  endfunction

  function automatic int unsigned p_side(input int unsigned w_in, input int unsigned pad);
    return w_in + 2 * pad;
  endfunction

  localparam int unsigned W_BEATS = w_beats(DEF_CH_IN, DEF_K_S);
  localparam int unsigned P_SIDE  = p_side(DEF_W_IN, DEF_PAD);
  localparam int unsigned WADD_W  = cw(W_BEATS);
  localparam int unsigned INADD_W = cw(DEF_CH_IN);

endpackage

// File: rtl/conv_stream_scheduler_if.sv
// Control, upstream bit-stream handshakes and datapath write strobes of the scheduler.
interface conv_stream_scheduler_if
  import conv_sched_pkg::*;
#(
  parameter int unsigned ch_in = DEF_CH_IN,
  parameter int unsigned k_s   = DEF_K_S
) ();

  localparam int unsigned WADD_W_L  = cw(w_beats(ch_in, k_s));
  localparam int unsigned INADD_W_L = cw(ch_in);

  logic                 start;
  logic                 w_valid;
  logic                 w_bit;
  logic                 w_ready;
  logic                 px_valid;
  logic                 px_bit;
  logic                 px_ready;
  logic [WADD_W_L-1:0]  stream_w_add;
  logic                 stream_w_en;
  logic [INADD_W_L-1:0] stream_in_add;
  logic                 stream_in_en;
  logic                 busy;
  logic                 done;

  modport master (
    output start, w_valid, w_bit, px_valid, px_bit,
    input  w_ready, px_ready, stream_w_add, stream_w_en,
    input  stream_in_add, stream_in_en, busy, done
  );

  modport slave (
    input  start, w_valid, w_bit, px_valid, px_bit,
    output w_ready, px_ready, stream_w_add, stream_w_en,
    output stream_in_add, stream_in_en, busy, done
  );

endinterface

// File: rtl/frame_scan_counter.sv
// Channel/column/row scan over the zero-padded frame, flagging border positions and the final beat.
module frame_scan_counter
  import conv_sched_pkg::*;
#(
  parameter int unsigned CH_IN = DEF_CH_IN,
  parameter int unsigned W_IN  = DEF_W_IN,
  parameter int unsigned PAD   = DEF_PAD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_adv,
  output logic [cw(CH_IN)-1:0] o_ch,
  output logic                 o_is_pad,
  output logic                 o_last
);

  localparam int unsigned P    = p_side(W_IN, PAD);
  localparam int unsigned CH_W = cw(CH_IN);
  localparam int unsigned RC_W = cw(P);
  localparam int unsigned HI   = W_IN + PAD;

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_IN - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(P - 1);

  logic [CH_W-1:0] r_ch;
  logic [RC_W-1:0] r_col;
  logic [RC_W-1:0] r_row;
  logic            w_ch_wrap;
  logic            w_col_wrap;
  logic            w_row_wrap;

  assign w_ch_wrap  = (r_ch == CH_LAST);
  assign w_col_wrap = (r_col == RC_LAST);
  assign w_row_wrap = (r_row == RC_LAST);

  // Without a border every position is interior; the compare would be constant.
  if (PAD == 0) begin : g_nopad
    assign o_is_pad = 1'b0;
  end else begin : g_pad
    assign o_is_pad = (32'(r_row) < PAD) || (32'(r_row) >= HI) ||
                      (32'(r_col) < PAD) || (32'(r_col) >= HI);
  end

  assign o_ch   = r_ch;
  assign o_last = w_ch_wrap && w_col_wrap && w_row_wrap;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_ch  <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_ch_wrap) begin
        r_ch <= '0;
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_row_wrap ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        r_ch <= r_ch + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_stream_scheduler.sv
// Layer-pass sequencer: loads the kernel bit stream, scans the padded activation frame, then flushes.
module conv_stream_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned ch_in        = DEF_CH_IN,
  parameter int unsigned k_s          = DEF_K_S,
  parameter int unsigned w_in         = DEF_W_IN,
  parameter int unsigned pad          = DEF_PAD,
  parameter int unsigned drain_cycles = DEF_DRAIN
) (
  input  logic                    clk,
  input  logic                    reset,
  conv_stream_scheduler_if.slave  bus
);

  localparam int unsigned W_N     = w_beats(ch_in, k_s);
  localparam int unsigned WADD_WL = cw(W_N);
  localparam int unsigned INADD_L = cw(ch_in);
  localparam int unsigned DR_W    = cw(drain_cycles);

  localparam logic [WADD_WL-1:0] W_LAST  = WADD_WL'(W_N - 1);
  localparam logic [DR_W-1:0]    DR_LAST = DR_W'(drain_cycles - 1);

  sched_state_t         r_state;
  sched_state_t         w_next;
  logic [WADD_WL-1:0]   r_w_cnt;
  logic [DR_W-1:0]      r_dr_cnt;
  logic [INADD_L-1:0]   w_ch;
  logic                 w_is_pad;
  logic                 w_last;
  logic                 w_w_hs;
  logic                 w_px_hs;
  logic                 w_adv;
  logic                 w_scan_clr;

  assign w_w_hs     = (r_state == LOAD_W) && bus.w_valid;
  assign w_px_hs    = (r_state == STREAM) && !w_is_pad && bus.px_valid;
  // Border positions advance on their own; interior ones wait for upstream data.
  assign w_adv      = (r_state == STREAM) && (w_is_pad || bus.px_valid);
  assign w_scan_clr = (r_state != STREAM);

  frame_scan_counter #(
    .CH_IN (ch_in),
    .W_IN  (w_in),
    .PAD   (pad)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_scan_clr),
    .i_adv    (w_adv),
    .o_ch     (w_ch),
    .o_is_pad (w_is_pad),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_w_cnt  <= '0;
      r_dr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_w_hs) begin
        r_w_cnt <= (r_w_cnt == W_LAST) ? '0 : r_w_cnt + 1'b1;
      end
      r_dr_cnt <= ((r_state == DRAIN) && (r_dr_cnt != DR_LAST)) ? r_dr_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next            = r_state;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.w_ready       = 1'b0;
    bus.px_ready      = 1'b0;
    bus.stream_w_add  = '0;
    bus.stream_w_en   = 1'b0;
    bus.stream_in_add = '0;
    bus.stream_in_en  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) w_next = LOAD_W;
      end
      LOAD_W: begin
        bus.busy         = 1'b1;
        bus.w_ready      = 1'b1;
        bus.stream_w_add = r_w_cnt;
        bus.stream_w_en  = bus.w_valid & bus.w_bit;
        if (bus.w_valid && (r_w_cnt == W_LAST)) w_next = STREAM;
      end
      STREAM: begin
        bus.busy          = 1'b1;
        bus.px_ready      = !w_is_pad;
        bus.stream_in_add = w_ch;
        bus.stream_in_en  = w_px_hs & bus.px_bit;
        if (w_adv && w_last) w_next = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (r_dr_cnt == DR_LAST) w_next = FINISH;
      end
      FINISH: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_stream_scheduler.sv
// Scoreboard bench: drivers queue expected write beats, a negedge monitor pops and compares them.
module tb_conv_stream_scheduler;
  import conv_sched_pkg::*;

  localparam int unsigned CH = 4;
  localparam int unsigned KS = 3;
  localparam int unsigned WI = 4;
  localparam int unsigned DR = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic w_valid = 1'b0;
  logic w_bit = 1'b0;
  logic px_valid = 1'b0;
  logic px_bit = 1'b0;
  bit   sel = 1'b0;

  always #5 clk = ~clk;

  conv_stream_scheduler_if #(.ch_in(CH), .k_s(KS)) if_p1 ();
  conv_stream_scheduler_if #(.ch_in(CH), .k_s(KS)) if_p0 ();

  assign if_p1.start    = start & ~sel;
  assign if_p1.w_valid  = w_valid;
  assign if_p1.w_bit    = w_bit;
  assign if_p1.px_valid = px_valid;
  assign if_p1.px_bit   = px_bit;
  assign if_p0.start    = start & sel;
  assign if_p0.w_valid  = w_valid;
  assign if_p0.w_bit    = w_bit;
  assign if_p0.px_valid = px_valid;
  assign if_p0.px_bit   = px_bit;

  conv_stream_scheduler #(
    .ch_in(CH), .k_s(KS), .w_in(WI), .pad(1), .drain_cycles(DR)
  ) dut_p1 (
    .clk(clk), .reset(reset), .bus(if_p1.slave)
  );

  conv_stream_scheduler #(
    .ch_in(CH), .k_s(KS), .w_in(WI), .pad(0), .drain_cycles(DR)
  ) dut_p0 (
    .clk(clk), .reset(reset), .bus(if_p0.slave)
  );

  logic       m_w_ready, m_px_ready, m_w_en, m_in_en, m_busy, m_done;
  logic [5:0] m_w_add;
  logic [1:0] m_in_add;

  assign m_w_ready  = sel ? if_p0.w_ready       : if_p1.w_ready;
  assign m_px_ready = sel ? if_p0.px_ready      : if_p1.px_ready;
  assign m_w_en     = sel ? if_p0.stream_w_en   : if_p1.stream_w_en;
  assign m_in_en    = sel ? if_p0.stream_in_en  : if_p1.stream_in_en;
  assign m_busy     = sel ? if_p0.busy          : if_p1.busy;
  assign m_done     = sel ? if_p0.done          : if_p1.done;
  assign m_w_add    = sel ? if_p0.stream_w_add  : if_p1.stream_w_add;
  assign m_in_add   = sel ? if_p0.stream_in_add : if_p1.stream_in_add;

  typedef struct { logic [5:0] add; logic b; } wexp_t;
  typedef struct { logic [1:0] add; logic b; } pexp_t;

  wexp_t wq[$];
  pexp_t pq[$];

  logic [35:0] wpat;
  logic [63:0] pxpat;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc = 0, n_busy = 0, n_wr = 0, n_whs = 0, n_pxhs = 0, n_done = 0;
  int last_w_cyc = 0, first_pxr = -1, last_px_cyc = 0, done_cyc = 0;
  bit prev_done = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic mon_loop();
    wexp_t we;
    pexp_t pe;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cyc++;
        if (prev_done) check("busy_after_done", m_busy, 0);
        prev_done = m_done;
        if (m_busy) n_busy++;
        if (m_done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (!m_busy) check("idle_quiet", {m_px_ready, m_done, m_in_add}, 0);
        if (m_w_ready) begin
          n_wr++;
          check("load_px_quiet", {m_px_ready, m_in_en, m_in_add}, 0);
        end else begin
          check("w_side_off", {m_w_en, m_w_add}, 0);
        end
        if (m_w_ready && w_valid) begin
          n_whs++;
          last_w_cyc = cyc;
          first_pxr  = -1;
          if (wq.size() == 0) check("w_unexpected_beat", m_w_add, -1);
          else begin
            we = wq.pop_front();
            check("w_add", m_w_add, we.add);
            check("w_en", m_w_en, we.b);
          end
        end
        if (m_px_ready && first_pxr < 0) first_pxr = cyc;
        if (m_px_ready && px_valid) begin
          n_pxhs++;
          last_px_cyc = cyc;
          if (pq.size() == 0) check("px_unexpected_beat", m_in_add, -1);
          else begin
            pe = pq.pop_front();
            check("px_add", m_in_add, pe.add);
            check("px_en", m_in_en, pe.b);
          end
        end else begin
          check("px_en_off", m_in_en, 0);
        end
      end
    end
  endtask

  task automatic drive_w(input int n);
    int k = 0;
    int g = 0;
    while (k < n && g < 400) begin
      w_valid = 1'b1;
      w_bit   = wpat[k];
      if (m_w_ready) begin
        wq.push_back('{add: 6'(k), b: wpat[k]});
        k++;
      end
      @(posedge clk); #1;
      g++;
    end
    w_valid = 1'b0;
    check("w_beats_issued", k, n);
  endtask

  task automatic drive_px(input int n, input bit gaps);
    int k = 0;
    int g = 0;
    logic v;
    while (k < n && g < 1000) begin
      v = !gaps || ($urandom_range(0, 1) == 1);
      px_valid = v;
      px_bit   = pxpat[k];
      if (v && m_px_ready) begin
        pq.push_back('{add: 2'(k % CH), b: pxpat[k]});
        k++;
      end
      @(posedge clk); #1;
      g++;
    end
    px_valid = 1'b0;
    check("px_beats_issued", k, n);
  endtask

  task automatic run_pass(input bit gaps, input bit stray, input int exp_busy,
                          input int exp_first, input int exp_tail, input int n_px);
    int b0, wr0, w0, p0, d0, t;
    b0 = n_busy; wr0 = n_wr; w0 = n_whs; p0 = n_pxhs; d0 = n_done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    fork
      drive_w(36);
      drive_px(n_px, gaps);
      if (stray) begin
        repeat (60) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    t = 0;
    while (n_done == d0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_pulses", n_done - d0, 1);
    check("w_handshakes", n_whs - w0, 36);
    check("px_handshakes", n_pxhs - p0, n_px);
    check("first_px_ready_gap", first_pxr - last_w_cyc, exp_first);
    check("last_px_to_done", done_cyc - last_px_cyc, exp_tail);
    check("wq_drained", wq.size(), 0);
    check("pq_drained", pq.size(), 0);
    if (exp_busy >= 0) begin
      check("busy_cycles", n_busy - b0, exp_busy);
      check("w_ready_cycles", n_wr - wr0, 36);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, g, d0, b0, w0;
    fork
      mon_loop();
    join_none
    wpat  = 36'h9A5C31E7B;
    pxpat = 64'hD3A50F96C3E17B28;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_p1", {if_p1.busy, if_p1.done, if_p1.w_ready, if_p1.px_ready,
                           if_p1.stream_w_en, if_p1.stream_in_en,
                           if_p1.stream_w_add, if_p1.stream_in_add}, 0);
    check("reset_out_p0", {if_p0.busy, if_p0.done, if_p0.w_ready, if_p0.px_ready,
                           if_p0.stream_w_en, if_p0.stream_in_en,
                           if_p0.stream_w_add, if_p0.stream_in_add}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_pass(1'b0, 1'b1, 185, 29, 33, 64);
    run_pass(1'b1, 1'b0, -1, 29, 33, 64);

    // Abort a pass at weight beat 20 and confirm nothing of it survives.
    d0 = n_done; w0 = n_whs;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0; g = 0;
    while (k < 20 && g < 100) begin
      w_valid = 1'b1;
      w_bit   = wpat[k];
      if (m_w_ready) begin
        wq.push_back('{add: 6'(k), b: wpat[k]});
        k++;
      end
      @(posedge clk); #1;
      g++;
    end
    w_bit = wpat[20];
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_out", {m_busy, m_done, m_w_ready, m_px_ready, m_w_en, m_in_en,
                        m_w_add, m_in_add}, 0);
    reset   = 1'b0;
    w_valid = 1'b0;
    b0 = n_busy;
    repeat (10) @(posedge clk);
    #1;
    check("abort_w_beats", n_whs - w0, 20);
    check("abort_wq_empty", wq.size(), 0);
    check("abort_no_done", n_done - d0, 0);
    check("abort_stays_idle", n_busy - b0, 0);

    run_pass(1'b0, 1'b0, 185, 29, 33, 64);

    sel = 1'b1;
    @(posedge clk); #1;
    run_pass(1'b0, 1'b1, 105, 1, 5, 64);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
